// File: rtl/pipe_rca_pkg.sv
// Shared constants and mode encoding for the pipelined ripple-carry adder.
package pipe_rca_pkg;

   localparam int PIPE_RCA_WIDTH  = 32;
   localparam int PIPE_RCA_STAGES = 4;

   // Operation select carried on the 'sub' input
   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   // True when the raw mode bit selects subtraction
   function automatic logic is_sub(input logic mode);
      return mode_e'(mode) == MODE_SUB;
   endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder slice. Also exposes the carry
// into the top bit so the last slice can derive signed overflow.
module rca_slice #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_ci,
   output logic [W-1:0] o_s,
   output logic         o_co,
   output logic         o_c_msb
);

   logic c_run;

   // Bit-serial carry ripple from LSB to MSB
   always_comb begin
      o_s     = '0;
      o_c_msb = i_ci;
      c_run   = i_ci;
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) begin
            o_c_msb = c_run;
         end
         o_s[i] = i_a[i] ^ i_b[i] ^ c_run;
         c_run  = (i_a[i] & i_b[i]) | (c_run & (i_a[i] ^ i_b[i]));
      end
      o_co = c_run;
   end

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds slice k of the
// operands; unconsumed operand bits travel with the stage and the partial
// sum grows by one slice per stage. The whole pipe advances together
// whenever the output register is empty or being drained.
module pipe_rca
   import pipe_rca_pkg::*;
#(
   parameter int WIDTH  = PIPE_RCA_WIDTH,
   parameter int STAGES = PIPE_RCA_STAGES
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int SLICE = WIDTH / STAGES;

   if ((WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipe_rca: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
   end

   logic             w_adv;
   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;

   // Subtraction is a + ~b + 1; ci only matters when adding
   assign w_sub    = is_sub(sub);
   assign w_b_eff  = w_sub ? ~b : b;
   assign w_cin    = w_sub ? 1'b1 : ci;
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   genvar gi;
   for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * SLICE;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]      w_a_in;
      logic [REM-1:0]      w_b_in;
      logic                w_c_in;
      logic                w_v_in;
      logic [SLICE-1:0]    w_sum;
      logic                w_co;
      logic                w_cmsb;
      logic [LO+SLICE-1:0] w_s_next;

      logic                r_v;
      logic                r_c;
      logic [LO+SLICE-1:0] r_s;

      if (gi == 0) begin : g_src
         assign w_a_in   = a;
         assign w_b_in   = w_b_eff;
         assign w_c_in   = w_cin;
         assign w_v_in   = in_valid;
         assign w_s_next = w_sum;
      end else begin : g_src
         assign w_a_in   = g_stage[gi-1].g_mid.r_a;
         assign w_b_in   = g_stage[gi-1].g_mid.r_b;
         assign w_c_in   = g_stage[gi-1].r_c;
         assign w_v_in   = g_stage[gi-1].r_v;
         assign w_s_next = {w_sum, g_stage[gi-1].r_s};
      end

      rca_slice #(
         .W (SLICE)
      ) u_slice (
         .i_a     (w_a_in[SLICE-1:0]),
         .i_b     (w_b_in[SLICE-1:0]),
         .i_ci    (w_c_in),
         .o_s     (w_sum),
         .o_co    (w_co),
         .o_c_msb (w_cmsb)
      );

      // Stage valid, carry and partial sum: load from predecessor on advance
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_adv) begin
            r_v <= w_v_in;
            r_c <= w_co;
            r_s <= w_s_next;
         end
      end

      if (gi < STAGES - 1) begin : g_mid
         logic [REM-SLICE-1:0] r_a;
         logic [REM-SLICE-1:0] r_b;
         logic                 w_cmsb_unused;

         // Only the final slice needs the MSB carry
         assign w_cmsb_unused = w_cmsb;

         // Carry the not-yet-added operand slices forward
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a_in[REM-1:SLICE];
               r_b <= w_b_in[REM-1:SLICE];
            end
         end
      end else begin : g_tail
         logic r_ovf;

         // Signed overflow: carry into MSB differs from carry out of MSB
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               r_ovf <= 1'b0;
            end else if (w_adv) begin
               r_ovf <= w_cmsb ^ w_co;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].r_v;
   assign s         = g_stage[STAGES-1].r_s;
   assign co        = g_stage[STAGES-1].r_c;
   assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;

endmodule

// File: doc/pipe_rca.md
PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline depth; WIDTH SHALL be a multiple of STAGES; SLICE = WIDTH/STAGES.
REQ-003 The block SHALL have port clock  input  1  single rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operand set presented.
REQ-006 The block SHALL have port in_ready  output  1  operand set accepted this cycle when in_valid high.
REQ-007 The block SHALL have port a  input  WIDTH  operand A.
REQ-008 The block SHALL have port b  input  WIDTH  operand B.
REQ-009 The block SHALL have port ci  input  1  carry-in (add mode only).
REQ-010 The block SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 The block SHALL have port out_valid  output  1  result valid.
REQ-012 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 The block SHALL have port s  output  WIDTH  sum/difference.
REQ-014 The block SHALL have port co  output  1  carry-out (add) / not-borrow (sub).
REQ-015 The block SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Add mode SHALL compute {co,s} = a + b + ci, modulo 2^(WIDTH+1).
REQ-017 Sub mode SHALL compute {co,s} = a + ~b + 1; ci SHALL be ignored.
REQ-018 ovf SHALL be high iff the MSBs of a and the effective b agree and s MSB differs.
REQ-019 Stage k (0..STAGES-1) SHALL add bits [k*SLICE +: SLICE] using the carry registered by stage k-1 (stage 0 uses the effective carry-in); operand slices not yet consumed SHALL travel with the stage.
REQ-020 Global advance enable SHALL be adv = ~out_valid | out_ready; in_ready SHALL equal adv.
REQ-021 When adv is high, every stage register, including its valid bit, SHALL load from its predecessor; when low, all SHALL hold.
REQ-022 Latency SHALL be exactly STAGES cycles from an accepted transfer to out_valid when out_ready stays high; throughput SHALL be one result per cycle.
REQ-023 A transfer with in_valid low during adv SHALL insert a bubble (valid=0) that never raises out_valid.
REQ-024 s, co, ovf SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 Results SHALL leave in acceptance order; no operand set SHALL be dropped or duplicated under any out_ready pattern.
REQ-026 Simultaneous input accept and output retire in one cycle SHALL both take effect.

Reset
REQ-027 Asserting reset_n low SHALL immediately clear all stage valid bits, forcing out_valid=0 and in_ready=1, regardless of clock.
REQ-028 Reset SHALL force s=0, co=0, ovf=0; in-flight operations SHALL be discarded.
REQ-029 The first rising clock edge after reset_n deasserts SHALL be able to accept an operand set.

Structure
REQ-030 Package pipe_rca_pkg SHALL hold default WIDTH and STAGES constants and the add/sub mode encoding.
REQ-031 One combinational sub-module rca_slice (SLICE-bit ripple-carry adder: a, b, ci -> s, co, plus carry into MSB for ovf) SHALL be instantiated once per stage.
REQ-032 Parameter check SHALL fail elaboration when WIDTH mod STAGES != 0.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-033 a=FFFF_FFFF, b=0, ci=1, sub=0 -> 4 cycles later s=0000_0000, co=1, ovf=0.
REQ-034 Back-to-back: (0000_FFFF+FFFF_0000, ci=0) then (135F_A562+3561_4642) -> consecutive cycles s=FFFF_FFFF co=0, then s=48C0_EBA4 co=0.
REQ-035 Sub: a=0, b=1 -> s=FFFF_FFFF, co=0, ovf=0; add a=7FFF_FFFF, b=1, ci=0 -> s=8000_0000, ovf=1.
REQ-036 Stall: stream 6 ops, hold out_ready=0 for 3 cycles once out_valid rises -> in_ready low while full, outputs frozen, all 6 results emerge in order.
REQ-037 Reset mid-stream: assert reset_n with 3 ops in flight -> out_valid=0 immediately, none of the 3 ever appear, next op after release returns in 4 cycles.
